muldiv_ctrl: RTL and testbench

//   Sequencer for the shared multiplier and iterative divider behind the EX stage.

---
 rtl/muldiv_ctrl.sv | 128 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier and iterative divider behind EX: latches one
// mul/div operation, stalls the pipe while it runs, then issues one HI/LO write.
`timescale 1ns/1ps

module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic        op_div,
  input  logic        op_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t          state_reg;
  logic [31:0]     a_reg;
  logic [31:0]     b_reg;
  logic            signed_reg;
  logic [31:0]     hi_reg;
  logic [31:0]     lo_reg;
  logic [CW-1:0]   cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op_valid) begin
            a_reg      <= src_a;
            b_reg      <= src_b;
            signed_reg <= op_signed;
            if (!op_div) begin
              state_reg <= MUL_WAIT;
              cnt_reg   <= CW'(MUL_LAT - 1);
            end else if (src_b != 32'd0) begin
              state_reg <= DIV_RUN;
            end else begin
              // Divide by zero resolves without touching the divider.
              state_reg <= DONE;
              hi_reg    <= src_a;
              lo_reg    <= 32'hFFFF_FFFF;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_reg == '0) begin
            hi_reg    <= mul_result[63:32];
            lo_reg    <= mul_result[31:0];
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DIV_RUN: begin
          if (div_ready) begin
            hi_reg    <= div_result[63:32];
            lo_reg    <= div_result[31:0];
            state_reg <= DONE;
          end
        end
        DONE: begin
          // op_valid is still the same instruction here; EX advances on this edge.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

  assign stallreq = !rst && !flush &&
                    (((state_reg == IDLE) && op_valid) ||
                     (state_reg == MUL_WAIT) || (state_reg == DIV_RUN));

  assign mul_signed = (state_reg == MUL_WAIT) && signed_reg;
  assign mul_ina    = (state_reg == MUL_WAIT) ? a_reg : 32'd0;
  assign mul_inb    = (state_reg == MUL_WAIT) ? b_reg : 32'd0;

  assign div_start  = (state_reg == DIV_RUN);
  assign div_signed = signed_reg;
  assign div_opa    = a_reg;
  assign div_opb    = b_reg;
  // rst resets the divider itself, so no annul pulse is needed then.
  assign div_annul  = !rst && flush && (state_reg == DIV_RUN);

  assign hilo_we  = !rst && !flush && (state_reg == DONE);
  assign hi_wdata = hi_reg;
  assign lo_wdata = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural multiplier/divider models and
// a spec-level reference for results and stall lengths, random plus directed ops.
`timescale 1ns/1ps

module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic        op_div;
  logic        op_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        busy;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int div_lat   = 1;
  int dcnt      = 0;
  logic [63:0] mul_pipe = '0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(op_valid), .op_div(op_div), .op_signed(op_signed),
    .src_a(src_a), .src_b(src_b),
    .stallreq(stallreq), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  // Architectural result: {hi,lo} of a MULT/MULTU/DIV/DIVU, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic d, input logic s,
                                             input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    int sa, sb;
    int unsigned ua, ub;
    if (!d) begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      return 64'(x * y);
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    ua = a;
    ub = b;
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Multiplier: one register stage, result valid MUL_LAT-1 edges after operands.
  always @(posedge clk) mul_pipe <= ref_result(1'b0, mul_signed, mul_ina, mul_inb);
  assign mul_result = mul_pipe;

  // Divider: ready in the div_lat-th cycle that div_start is held.
  always @(posedge clk) begin
    if (rst || !div_start || div_annul || div_ready) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign div_ready  = div_start && (dcnt == div_lat - 1);
  assign div_result = (div_opb == 32'd0) ? 64'd0 : ref_result(1'b1, div_signed, div_opa, div_opb);

  task automatic do_op(input logic d, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int lat);
    logic [63:0] exp;
    int exp_stalls, stalls;
    bit got, saw_start;
    logic [31:0] h, l;
    logic ds_done;
    exp = ref_result(d, s, a, b);
    exp_stalls = !d ? 1 + MUL_LAT : (b == 32'd0 ? 1 : 1 + lat);
    div_lat = lat;
    op_valid = 1'b1; op_div = d; op_signed = s; src_a = a; src_b = b;
    stalls = 0; got = 0; saw_start = 0; h = '0; l = '0; ds_done = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (stallreq) stalls++;
      if (div_start) saw_start = 1;
      if (hilo_we) begin
        got = 1; h = hi_wdata; l = lo_wdata; ds_done = div_start;
      end
      @(posedge clk); #1;
      if (!got) begin
        src_a = $urandom; src_b = $urandom; op_signed = 1'($urandom);
      end
    end
    op_valid = 1'b0;
    $display("op div=%0d sgn=%0d a=%h b=%h lat=%0d -> hi=%h lo=%h stalls=%0d", d, s, a, b, lat, h, l, stalls);
    check_cnt++;
    if (!got) $display("FAIL op_timeout: hilo_we seen %0d required 1", got);
    else pass_cnt++;
    check_cnt++;
    if (stalls !== exp_stalls) $display("FAIL stall_cycles: got %0d required %0d", stalls, exp_stalls);
    else pass_cnt++;
    check_cnt++;
    if ({h, l} !== exp) $display("FAIL hilo_value: got %h required %h", {h, l}, exp);
    else pass_cnt++;
    check_cnt++;
    if (ds_done !== 1'b0) $display("FAIL div_start_in_done: got %b required 0", ds_done);
    else pass_cnt++;
    if (d && b == 32'd0) begin
      check_cnt++;
      if (saw_start) $display("FAIL div0_started: got %0d required 0", saw_start);
      else pass_cnt++;
    end
  endtask

  task automatic expect_idle(input int n);
    int writes, busy_cnt;
    writes = 0; busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (hilo_we) writes++;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    check_cnt++;
    if (writes !== 0 || busy_cnt !== 0)
      $display("FAIL idle_quiet: got writes=%0d busy=%0d required 0/0", writes, busy_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b1;
    src_a = 32'h1234_5678; src_b = 32'h0000_0003;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_cnt++;
    if ({stallreq, busy, hilo_we, div_start, div_annul, mul_signed} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000", {stallreq, busy, hilo_we, div_start, div_annul, mul_signed});
    else pass_cnt++;
    check_cnt++;
    if ({mul_ina, mul_inb, hi_wdata, lo_wdata, div_opa, div_opb} !== 192'd0)
      $display("FAIL reset_data: got %h required 0", {mul_ina, mul_inb, hi_wdata, lo_wdata, div_opa, div_opb});
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    $display("reset done");
  endtask

  task automatic test_spec_vectors();
    do_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 1);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33);
    do_op(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 1);
    expect_idle(2);
  endtask

  task automatic test_flush_div();
    div_lat = 33;
    op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b0; src_a = 32'd1000; src_b = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({div_annul, stallreq, hilo_we} !== 3'b100)
      $display("FAIL flush_div_cycle: got annul/stall/we=%b required 100", {div_annul, stallreq, hilo_we});
    else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({busy, div_annul, div_start} !== 3'b000)
      $display("FAIL flush_div_after: got busy/annul/start=%b required 000", {busy, div_annul, div_start});
    else pass_cnt++;
    @(posedge clk); #1;
    $display("flush in DIV_RUN cycle 10 done");
    expect_idle(40);
  endtask

  task automatic test_flush_done_idle();
    op_valid = 1'b1; op_div = 1'b0; op_signed = 1'b1; src_a = 32'd9; src_b = 32'd9;
    repeat (1 + MUL_LAT) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({busy, hilo_we} !== 2'b10)
      $display("FAIL flush_done: got busy/we=%b required 10", {busy, hilo_we});
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    check_cnt++;
    if ({busy, stallreq} !== 2'b00)
      $display("FAIL flush_idle_op: got busy/stall=%b required 00", {busy, stallreq});
    else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    $display("flush in DONE and IDLE done");
    expect_idle(3);
  endtask

  task automatic test_rst_mid();
    div_lat = 33;
    op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b1; src_a = 32'hDEAD_0000; src_b = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({div_annul, hilo_we, stallreq} !== 3'b000)
      $display("FAIL rst_mid: got annul/we/stall=%b required 000", {div_annul, hilo_we, stallreq});
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    $display("reset mid-divide done");
    expect_idle(40);
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 1);
    do_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0013, 12);
    expect_idle(5);
  endtask

  task automatic test_random();
    logic d, s;
    logic [31:0] a, b;
    int lat, gap;
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom); s = 1'($urandom); a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom));
      if (d && s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat = $urandom_range(1, 40);
      do_op(d, s, a, b, lat);
      gap = $urandom_range(0, 2);
      if (gap != 0) expect_idle(gap);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_flush_div();
    test_flush_done_idle();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
